// File: rtl/squash_game_ctrl.sv
// squash_game_ctrl
//   Game-flow sequencer for the solo squash datapath. It steps through the
//   attract, serve, play, miss and game-over phases, keeps the lives count and
//   a two-digit BCD score, and drives the datapath's new-game and run controls.
//
// Ports
//   clk         pixel clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle end-of-frame pulse
//   start_n     start button, active low (already synchronised)
//   pause_n     pause button, active low (already synchronised)
//   hit         ball/paddle hit flag from the datapath (level)
//   ball_out    ball passed the paddle column without a hit (level)
//   new_game    one-cycle pulse: datapath re-centres paddle and ball
//   run         1 = datapath animates (feeds the datapath pause_n)
//   state       0=ATTRACT 1=SERVE 2=PLAY 3=MISS 4=OVER
//   lives       remaining lives
//   score_bcd   [7:4] tens, [3:0] units
//   miss_tone   high while in MISS
module squash_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_n,
  input  logic       pause_n,
  input  logic       hit,
  input  logic       ball_out,
  output logic       new_game,
  output logic       run,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [7:0] score_bcd,
  output logic       miss_tone
);

  localparam logic [2:0] ST_ATTRACT = 3'd0;
  localparam logic [2:0] ST_SERVE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_MISS    = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  localparam logic [9:0] SERVE_LAST = 10'(SERVE_FRAMES - 1);
  localparam logic [9:0] MISS_LAST  = 10'(MISS_FRAMES - 1);
  localparam logic [9:0] OVER_LAST  = 10'(OVER_FRAMES - 1);

  // BCD increment that saturates at 99 rather than wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [2:0] state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [9:0] cnt_q, cnt_d;
  logic       paused_q, paused_d;
  logic       new_game_q, new_game_d;
  logic       run_q, run_d;
  logic       miss_tone_q, miss_tone_d;
  logic       start_prev_q, pause_prev_q, hit_prev_q, ball_out_prev_q;

  // Prev registers reset to 0, so a button held through reset needs a
  // release and a fresh press before it counts.
  logic start_press_s, pause_press_s, hit_rise_s, out_rise_s;
  assign start_press_s = start_prev_q & ~start_n;
  assign pause_press_s = pause_prev_q & ~pause_n;
  assign hit_rise_s    = ~hit_prev_q & hit;
  assign out_rise_s    = ~ball_out_prev_q & ball_out;

  // Next-state logic for the phase sequencer and its bookkeeping.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    paused_d   = paused_q;
    new_game_d = 1'b0;
    case (state_q)
      ST_ATTRACT: begin
        if (start_press_s) begin
          state_d    = ST_SERVE;
          lives_d    = 2'(LIVES);
          score_d    = 8'h00;
          new_game_d = 1'b1;
        end else begin
          state_d = ST_ATTRACT;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PLAY: begin
        // A lost ball overrides a same-cycle hit or pause press.
        if (out_rise_s) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_OVER : ST_MISS;
        end else begin
          if (hit_rise_s) begin
            score_d = bcd_inc(score_q);
          end else begin
            score_d = score_q;
          end
          if (pause_press_s) begin
            paused_d = ~paused_q;
          end else begin
            paused_d = paused_q;
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            state_d    = ST_SERVE;
            new_game_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (cnt_q == OVER_LAST) begin
            state_d = ST_ATTRACT;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_ATTRACT;
      end
    endcase
    // Every state entry restarts the frame counter and drops any pause.
    if (state_d != state_q) begin
      cnt_d    = 10'd0;
      paused_d = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end
    run_d       = (state_d == ST_ATTRACT) | ((state_d == ST_PLAY) & ~paused_d);
    miss_tone_d = (state_d == ST_MISS);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_ATTRACT;
      lives_q         <= 2'd0;
      score_q         <= 8'h00;
      cnt_q           <= 10'd0;
      paused_q        <= 1'b0;
      new_game_q      <= 1'b0;
      run_q           <= 1'b1;
      miss_tone_q     <= 1'b0;
      start_prev_q    <= 1'b0;
      pause_prev_q    <= 1'b0;
      hit_prev_q      <= 1'b0;
      ball_out_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      cnt_q           <= cnt_d;
      paused_q        <= paused_d;
      new_game_q      <= new_game_d;
      run_q           <= run_d;
      miss_tone_q     <= miss_tone_d;
      start_prev_q    <= start_n;
      pause_prev_q    <= pause_n;
      hit_prev_q      <= hit;
      ball_out_prev_q <= ball_out;
    end
  end

  assign new_game  = new_game_q;
  assign run       = run_q;
  assign state     = state_q;
  assign lives     = lives_q;
  assign score_bcd = score_q;
  assign miss_tone = miss_tone_q;

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed bench for squash_game_ctrl with default parameters.
module tb_squash_game_ctrl;
  logic       clk = 1'b0;
  logic       reset, frame_tick, start_n, pause_n, hit, ball_out;
  logic       new_game, run, miss_tone;
  logic [2:0] state;
  logic [1:0] lives;
  logic [7:0] score_bcd;
  int checks = 0;
  int errors = 0;
  int ng_count;

  localparam logic [2:0] ATTRACT = 3'd0;
  localparam logic [2:0] SERVE   = 3'd1;
  localparam logic [2:0] PLAY    = 3'd2;
  localparam logic [2:0] MISS    = 3'd3;
  localparam logic [2:0] OVER    = 3'd4;

  squash_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_n(start_n),
    .pause_n(pause_n), .hit(hit), .ball_out(ball_out), .new_game(new_game),
    .run(run), .state(state), .lives(lives), .score_bcd(score_bcd),
    .miss_tone(miss_tone)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: a single-cycle frame_tick followed by one idle cycle.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic hit_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; tick(); tick(); tick();
      hit = 1'b0; tick(); tick();
    end
  endtask

  task automatic press_start();
    start_n = 1'b0; tick();
  endtask

  task automatic lose_ball();
    ball_out = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start_n = 1'b0; pause_n = 1'b1;
    hit = 1'b0; ball_out = 1'b0;
    tick(); tick();
    reset = 1'b0; tick();
    check_eq("rst_state", 32'(state), 32'(ATTRACT));
    check_eq("rst_lives", 32'(lives), 32'd0);
    check_eq("rst_score", 32'(score_bcd), 32'h00);
    check_eq("rst_run", 32'(run), 32'd1);
    check_eq("rst_newgame", 32'(new_game), 32'd0);
    check_eq("rst_tone", 32'(miss_tone), 32'd0);
    tick(); tick();
    check_eq("held_start_ignored", 32'(state), 32'(ATTRACT));
    start_n = 1'b1; tick();
    check_eq("release_no_move", 32'(state), 32'(ATTRACT));
    press_start();
    check_eq("start_serve", 32'(state), 32'(SERVE));
    check_eq("start_newgame", 32'(new_game), 32'd1);
    check_eq("start_lives", 32'(lives), 32'd3);
    check_eq("start_score", 32'(score_bcd), 32'h00);
    check_eq("serve_run", 32'(run), 32'd0);
    start_n = 1'b1; tick();
    check_eq("newgame_single", 32'(new_game), 32'd0);

    // SERVE lasts exactly 60 ticks.
    frames(59);
    check_eq("serve_59", 32'(state), 32'(SERVE));
    check_eq("serve_59_run", 32'(run), 32'd0);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check_eq("serve_60", 32'(state), 32'(PLAY));
    check_eq("play_run", 32'(run), 32'd1);
    tick();

    // Scoring with BCD carry and saturation.
    hit_pulses(1);
    check_eq("score_1", 32'(score_bcd), 32'h01);
    hit_pulses(9);
    check_eq("score_10", 32'(score_bcd), 32'h10);
    hit_pulses(2);
    check_eq("score_12", 32'(score_bcd), 32'h12);
    hit_pulses(86);
    check_eq("score_98", 32'(score_bcd), 32'h98);
    hit_pulses(3);
    check_eq("score_sat", 32'(score_bcd), 32'h99);

    // Hit and ball_out together: the lost ball wins.
    hit = 1'b1; ball_out = 1'b1; tick();
    check_eq("miss_lives", 32'(lives), 32'd2);
    check_eq("miss_state", 32'(state), 32'(MISS));
    check_eq("miss_score", 32'(score_bcd), 32'h99);
    check_eq("miss_tone", 32'(miss_tone), 32'd1);
    check_eq("miss_run", 32'(run), 32'd0);
    hit = 1'b0; ball_out = 1'b0;
    frames(89);
    check_eq("miss_89", 32'(state), 32'(MISS));
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check_eq("miss_to_serve", 32'(state), 32'(SERVE));
    check_eq("miss_newgame", 32'(new_game), 32'd1);
    ng_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (new_game) ng_count++;
    end
    check_eq("miss_newgame_once", 32'(ng_count), 32'd0);
    frames(60);
    check_eq("play_again", 32'(state), 32'(PLAY));

    // Pause toggling.
    pause_n = 1'b0; tick();
    check_eq("pause_run0", 32'(run), 32'd0);
    pause_n = 1'b1; tick();
    frames(3);
    check_eq("pause_hold", 32'(state), 32'(PLAY));
    pause_n = 1'b0; tick();
    check_eq("unpause_run1", 32'(run), 32'd1);
    pause_n = 1'b1; tick();

    // ball_out with a simultaneous pause press: pause is dropped.
    ball_out = 1'b1; pause_n = 1'b0; tick();
    check_eq("miss2_lives", 32'(lives), 32'd1);
    check_eq("miss2_state", 32'(state), 32'(MISS));
    ball_out = 1'b0; pause_n = 1'b1;
    frames(90 + 60);
    check_eq("play3_state", 32'(state), 32'(PLAY));
    check_eq("play3_unpaused", 32'(run), 32'd1);

    // Last ball: game over.
    lose_ball(); ball_out = 1'b0;
    check_eq("over_state", 32'(state), 32'(OVER));
    check_eq("over_lives", 32'(lives), 32'd0);
    check_eq("over_run", 32'(run), 32'd0);
    check_eq("over_tone", 32'(miss_tone), 32'd0);
    tick();
    press_start(); start_n = 1'b1;
    check_eq("over_start_ign", 32'(state), 32'(OVER));
    check_eq("over_no_newgame", 32'(new_game), 32'd0);
    frames(299);
    check_eq("over_299", 32'(state), 32'(OVER));
    check_eq("over_score_held", 32'(score_bcd), 32'h99);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check_eq("over_to_attract", 32'(state), 32'(ATTRACT));
    check_eq("attract_run", 32'(run), 32'd1);
    tick();

    // Reset while paused.
    press_start(); start_n = 1'b1;
    frames(60);
    pause_n = 1'b0; tick(); pause_n = 1'b1;
    check_eq("pre_reset_paused", 32'(run), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("mid_rst_state", 32'(state), 32'(ATTRACT));
    check_eq("mid_rst_lives", 32'(lives), 32'd0);
    check_eq("mid_rst_score", 32'(score_bcd), 32'h00);
    check_eq("mid_rst_run", 32'(run), 32'd1);
    check_eq("mid_rst_newgame", 32'(new_game), 32'd0);
    tick();

    // Start press coincident with frame_tick: SERVE still counts 60 from 0.
    start_n = 1'b0; frame_tick = 1'b1; tick();
    start_n = 1'b1; frame_tick = 1'b0;
    check_eq("tick_start_serve", 32'(state), 32'(SERVE));
    tick();
    frames(59);
    check_eq("tick_start_59", 32'(state), 32'(SERVE));
    frames(1);
    check_eq("tick_start_60", 32'(state), 32'(PLAY));
    check_eq("after_rst_unpaused", 32'(run), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
